// File: rtl/dm_pkg.sv
// Shared definitions for the data memory: access-type encodings and default size.
// Imported by dm, dm_ext and the control unit that generates DMOP.
package dm_pkg;

  // Default array depth in 32-bit words (4 KiB).
  localparam int unsigned DM_DEPTH_WORDS = 1024;

  localparam int unsigned DMOP_W = 3;

  // Access-type encodings driven on DMOP; 3'b101..3'b111 are reserved.
  localparam logic [DMOP_W-1:0] DM_W  = 3'b000;
  localparam logic [DMOP_W-1:0] DM_HS = 3'b001;
  localparam logic [DMOP_W-1:0] DM_HU = 3'b010;
  localparam logic [DMOP_W-1:0] DM_BS = 3'b011;
  localparam logic [DMOP_W-1:0] DM_BU = 3'b100;

endpackage

// File: rtl/dm_ext.sv
// Load extension: picks the addressed half/byte lane out of a raw word and
// sign- or zero-extends it according to DMOP.
// Ports:
//   word  - raw 32-bit word read from the array
//   lane  - ADDR[1:0], little-endian lane select
//   dmop  - access type
//   ext   - extended load value (0 for reserved encodings)
module dm_ext
  import dm_pkg::*;
(
  input  logic [31:0]       word,
  input  logic [1:0]        lane,
  input  logic [DMOP_W-1:0] dmop,
  output logic [31:0]       ext
);

  logic [15:0] half_v;
  logic [7:0]  byte_v;

  // Lane selection.
  always_comb begin
    half_v = lane[1] ? word[31:16] : word[15:0];
    case (lane)
      2'd0:    byte_v = word[7:0];
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      default: byte_v = word[31:24];
    endcase
  end

  // Extension.
  always_comb begin
    ext = '0;
    case (dmop)
      DM_W:    ext = word;
      DM_HS:   ext = {{16{half_v[15]}}, half_v};
      DM_HU:   ext = {16'h0000, half_v};
      DM_BS:   ext = {{24{byte_v[7]}}, byte_v};
      DM_BU:   ext = {24'h000000, byte_v};
      default: ext = '0;
    endcase
  end

endmodule

// File: rtl/dm.sv
// Data memory for the single-cycle MIPS datapath. Combinational loads with
// extension, clocked stores with lane merging, address-error detection that
// suppresses faulting accesses, and a per-store write log.
// Ports:
//   clk    - clock, state updates on rising edge
//   reset  - synchronous active-high, zeroes the whole array
//   WE     - store enable
//   ADDR   - byte address (ALU result)
//   WD     - store data (rt)
//   DMOP   - access type (see dm_pkg)
//   PC     - PC of the current instruction, used only by the write log
//   RD     - extended load data, 0 on address error
//   ADE    - address error: misaligned, out of range, or reserved DMOP
module dm
  import dm_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DM_DEPTH_WORDS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              WE,
  input  logic [31:0]       ADDR,
  input  logic [31:0]       WD,
  input  logic [DMOP_W-1:0] DMOP,
  input  logic [31:0]       PC,
  output logic [31:0]       RD,
  output logic              ADE
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic [31:0]   old_word;
  logic [31:0]   merged;
  logic [31:0]   ext;
  logic          misaligned;
  logic          out_of_range;
  logic          reserved_op;

  assign idx      = ADDR[AW+1:2];
  assign old_word = mem[idx];

  // Address error; any set high bit above the array means no aliasing.
  always_comb begin
    misaligned   = 1'b0;
    reserved_op  = 1'b0;
    out_of_range = |ADDR[31:AW+2];
    case (DMOP)
      DM_W:         misaligned = (ADDR[1:0] != 2'b00);
      DM_HS, DM_HU: misaligned = ADDR[0];
      DM_BS, DM_BU: misaligned = 1'b0;
      default:      reserved_op = 1'b1;
    endcase
    ADE = misaligned | out_of_range | reserved_op;
  end

  dm_ext u_ext (
    .word (old_word),
    .lane (ADDR[1:0]),
    .dmop (DMOP),
    .ext  (ext)
  );

  assign RD = ADE ? 32'h0000_0000 : ext;

  // Store merge against the current array contents (no bypass).
  always_comb begin
    merged = old_word;
    case (DMOP)
      DM_W: merged = WD;
      DM_HS, DM_HU: begin
        if (ADDR[1]) merged[31:16] = WD[15:0];
        else         merged[15:0]  = WD[15:0];
      end
      DM_BS, DM_BU: begin
        case (ADDR[1:0])
          2'd0:    merged[7:0]   = WD[7:0];
          2'd1:    merged[15:8]  = WD[7:0];
          2'd2:    merged[23:16] = WD[7:0];
          default: merged[31:24] = WD[7:0];
        endcase
      end
      default: merged = old_word;
    endcase
  end

  // Array update; reset wins over a simultaneous store.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
        mem[i] <= 32'h0000_0000;
      end
    end else if (WE && !ADE) begin
      mem[idx] <= merged;
      $display("@%h: *%h <= %h", PC, {ADDR[31:2], 2'b00}, merged);
    end
  end

endmodule

// File: tb/tb_dm.sv
// Scoreboard bench for dm: the driver pushes expected RD/ADE from a byte-level
// reference model, a monitor samples the DUT mid-cycle and compares.
module tb_dm;
  import dm_pkg::*;

  localparam int unsigned MEM_BYTES = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic        WE;
  logic [31:0] ADDR;
  logic [31:0] WD;
  logic [2:0]  DMOP;
  logic [31:0] PC;
  logic [31:0] RD;
  logic        ADE;

  always #5 clk = ~clk;

  dm #(.DEPTH_WORDS(1024)) dut (
    .clk   (clk),
    .reset (reset),
    .WE    (WE),
    .ADDR  (ADDR),
    .WD    (WD),
    .DMOP  (DMOP),
    .PC    (PC),
    .RD    (RD),
    .ADE   (ADE)
  );

  typedef struct {
    logic [31:0] rd;
    logic        ade;
    int          tag;
  } exp_t;

  exp_t        q[$];
  logic [31:0] model [1024];
  int          checks = 0;
  int          errors = 0;
  int          tag = 0;

  function automatic int unsigned acc_bytes(input logic [2:0] o);
    if (o == 3'd0) return 4;
    if (o == 3'd1 || o == 3'd2) return 2;
    return 1;
  endfunction

  function automatic logic m_ade(input logic [31:0] a, input logic [2:0] o);
    if (o > 3'd4) return 1'b1;
    if (a >= MEM_BYTES) return 1'b1;
    return (a % acc_bytes(o)) != 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input logic [2:0] o);
    logic [31:0] w, mask, v;
    int unsigned sh, bits;
    if (m_ade(a, o)) return 32'h0;
    w    = model[a / 4];
    bits = acc_bytes(o) * 8;
    if (bits == 32) return w;
    sh   = (a % 4) * 8;
    mask = (32'd1 << bits) - 32'd1;
    v    = (w >> sh) & mask;
    if ((o == 3'd1 || o == 3'd3) && v[bits-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic m_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] o);
    logic [31:0] mask;
    int unsigned sh, bits;
    bits = acc_bytes(o) * 8;
    sh   = (a % 4) * 8;
    mask = (bits == 32) ? 32'hFFFF_FFFF : ((32'd1 << bits) - 32'd1);
    model[a / 4] = (model[a / 4] & ~(mask << sh)) | ((d & mask) << sh);
  endtask

  // One CPU cycle: drive, record expectation, then advance the model past the edge.
  task automatic cyc(input logic rst, input logic we, input logic [31:0] a,
                     input logic [31:0] d, input logic [2:0] o);
    exp_t e;
    @(negedge clk);
    reset = rst;
    WE    = we;
    ADDR  = a;
    WD    = d;
    DMOP  = o;
    PC    = 32'h0040_0000 + 32'(tag) * 4;
    e.rd  = m_load(a, o);
    e.ade = m_ade(a, o);
    e.tag = tag;
    q.push_back(e);
    tag++;
    if (rst) begin
      for (int i = 0; i < 1024; i++) model[i] = 32'h0;
    end else if (we === 1'b1 && !e.ade) begin
      m_store(a, d, o);
    end
  endtask

  task automatic ld(input logic [31:0] a, input logic [2:0] o);
    cyc(1'b0, 1'b0, a, 32'h0, o);
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [2:0] o);
    cyc(1'b0, 1'b1, a, d, o);
  endtask

  // Monitor: sample between the driving negedge and the next posedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (RD !== e.rd || ADE !== e.ade) begin
          errors++;
          $display("FAIL op%0d: addr=%h dmop=%0d RD=%h ADE=%b, required RD=%h ADE=%b",
                   e.tag, ADDR, DMOP, RD, ADE, e.rd, e.ade);
        end
      end
    end
  end

  initial begin
    logic [31:0] a;
    int r;
    reset = 1'b1;
    WE    = 1'b0;
    ADDR  = 32'h0;
    WD    = 32'h0;
    DMOP  = DM_W;
    PC    = 32'h0;
    for (int i = 0; i < 1024; i++) model[i] = 32'h0;

    // Reset with an unknown store enable.
    cyc(1'b1, 1'bx, 32'h0, 32'hDEAD_BEEF, DM_W);
    ld(32'h0, DM_W);
    ld(32'hFFC, DM_W);

    st(32'h10, 32'h1122_3344, DM_W);
    ld(32'h10, DM_BS);
    ld(32'h13, DM_BS);
    ld(32'h12, DM_HS);

    st(32'h20, 32'h0000_80FF, DM_W);
    ld(32'h20, DM_BS);
    ld(32'h20, DM_BU);
    ld(32'h20, DM_HS);
    ld(32'h20, DM_HU);

    st(32'h30, 32'hAABB_CCDD, DM_W);
    st(32'h31, 32'h1234_5677, DM_BS);
    st(32'h32, 32'h0000_BEEF, DM_HU);
    ld(32'h30, DM_W);

    st(32'h40, 32'hCAFE_BABE, DM_W);
    st(32'h41, 32'h1111_1111, DM_W);
    st(32'h43, 32'h2222_2222, DM_HS);
    ld(32'h40, DM_W);

    st(32'h0, 32'h0102_0304, DM_W);
    st(32'h1000, 32'hFFFF_FFFF, DM_W);
    ld(32'h1000, DM_W);
    ld(32'h0, DM_W);
    ld(32'h0, 3'd5);

    // Same-cycle load/store shows the old value, then the new one.
    st(32'h60, 32'h5555_AAAA, DM_W);
    st(32'h60, 32'h0000_0012, DM_BU);
    ld(32'h60, DM_W);

    // Store during reset is dropped.
    cyc(1'b1, 1'b1, 32'h50, 32'h7777_7777, DM_W);
    ld(32'h50, DM_W);

    // Mid-program reset clears everything.
    for (int i = 0; i < 8; i++) st(32'(i * 4 + 32'h100), 32'h1000_0001 * 32'(i + 1), DM_W);
    cyc(1'b1, 1'b0, 32'h104, 32'h0, DM_W);
    for (int i = 0; i < 8; i++) ld(32'(i * 4 + 32'h100), DM_W);

    // Randomized traffic, concentrated on a small window so loads hit stores.
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       a = 32'($urandom_range(0, 63));
      else if (r == 7) a = 32'($urandom_range(0, 4095));
      else if (r == 8) a = 32'($urandom_range(4088, 4200));
      else             a = $urandom();
      cyc(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), a, $urandom(),
          3'($urandom_range(0, 7)));
    end

    @(negedge clk);
    reset = 1'b0;
    WE    = 1'b0;
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #3;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm.md
# dm

Data memory for the single-cycle MIPS datapath, directly downstream of the ALU: the ALU result is the byte address, and the register file's rt value is the store data. It performs word, halfword and byte stores with lane merging, and word, halfword and byte loads with sign/zero extension. It flags misaligned or out-of-range accesses and suppresses them. Reads are combinational and writes commit on the clock edge, so every load/store completes in one CPU cycle.

## Interface
- DEPTH_WORDS, 1024, number of 32-bit words (4 KiB); must be a power of two.
- AW, log2(DEPTH_WORDS) = 10, word-index width.
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; clears the whole array on the edge where it is sampled high.
- WE  input  1  store enable from control.
- ADDR  input  32  byte address (ALU result).
- WD  input  32  store data (rt); only the low half/byte lanes are used for sh/sb.
- DMOP  input  3  access type: 000 word; 001 half signed; 010 half unsigned; 011 byte signed; 100 byte unsigned; 101–111 reserved.
- PC  input  32  PC of the current instruction, used only for the write log.
- RD  output  32  load data after extension.
- ADE  output  1  address error: misaligned, out of range, or reserved DMOP.

## Operation
- Word index is ADDR[AW+1:2]. Byte lanes are little-endian: ADDR[1:0]=0 selects bits 7:0, and 3 selects bits 31:24.
- ADE is combinational. It is 1 when any of these holds:
  - DMOP=000 and ADDR[1:0]≠0.
  - DMOP∈{001,010} and ADDR[0]≠0.
  - ADDR ≥ 4·DEPTH_WORDS.
  - DMOP ≥ 101.
- ADE does not depend on WE.
- Load: RD is combinational from the current array contents.
  - Word: the full word.
  - Halfword: lane ADDR[1], sign-extended (001) or zero-extended (010).
  - Byte: lane ADDR[1:0], sign-extended (011) or zero-extended (100).
  - When ADE=1, RD=0.
- Store: on the rising edge with WE=1, reset=0 and ADE=0, the indexed word is replaced by the merged word.
  - Word: WD.
  - Half: WD[15:0] into lane ADDR[1]; the other half keeps its old value.
  - Byte: WD[7:0] into lane ADDR[1:0]; the other bytes keep their old values.
  - Signed and unsigned encodings behave identically for stores.
- Suppressed store (ADE=1): the array is unchanged and no log line is printed.
- Write log: each committed store prints "@%h: *%h <= %h" with PC, {ADDR[31:2],2'b00} and the full merged word.

## Timing
- Reset: the edge with reset=1 zeroes every word. Reset has priority over a simultaneous store, which is dropped and not logged. After that edge, every in-range aligned load returns 0.
- Reset asserted in the middle of a program clears all data on that same edge. No partial state survives.
- Load latency: 0 cycles, combinational from ADDR/DMOP to RD/ADE.
- Store latency: the store is visible on RD immediately after the committing edge.
- A load and store to the same address in the same cycle: RD shows the old value before the edge and the new value after it. There is no bypass.
- Back-to-back stores to the same word in consecutive cycles merge cumulatively. Each merge reads the array state left by the previous edge.
- Address wrap-around is never performed. An address ≥ 4·DEPTH_WORDS is an error, not aliased.
- X on WE or ADDR during reset does not corrupt the post-reset state.

## Structure
- Package dm_pkg holds:
  - DMOP encodings DM_W, DM_HS, DM_HU, DM_BS, DM_BU.
  - DEPTH_WORDS default.
- Sub-module dm_ext, purely combinational:
  - Inputs: raw word, ADDR[1:0], DMOP.
  - Output: the extended load value.
  - Top level dm holds the array, reset clear, store merge, ADE logic and logging.
- The control unit imports dm_pkg for DMOP generation.

## Test plan
- Reset, then load word 0x00000000 and 0x00000FFC: RD=0 and ADE=0.
- sw 0x11223344 at 0x10, then lb 0x10 → 0x00000044; lb 0x13 → 0x00000011; lh 0x12 → 0x00001122.
- sw 0x000080FF at 0x20, then lb 0x20 → 0xFFFFFFFF; lbu 0x20 → 0x000000FF; lh 0x20 → 0xFFFF80FF; lhu 0x20 → 0x000080FF.
- sw 0xAABBCCDD at 0x30; sb 0x31 with WD=0x12345677; sh 0x32 with WD=0x0000BEEF → word 0x30 reads 0xBEEF77DD. Log shows "*00000030 <= aabb77dd" and then "<= beef77dd".
- sw to 0x41 and sh to 0x43: ADE=1, word 0x40 unchanged, no log line. sw to 0x1000: ADE=1, lw 0x1000 gives RD=0, and word 0 is unchanged (no aliasing).
- Store to 0x50 with reset=1 in the same cycle: word 0x50 reads 0 afterward. Fill several words, assert reset for one cycle mid-program: all words read 0 afterward.
